irrigacao_multizona: RTL and testbench

Clocked, parametrised successor of the single-zone irrigation controller. It filters the tank-level sensors and raises the alarm. It drives the refill valve with hysteresis and schedules drip or sprinkler irrigation round-robin over N zones, one zone at a time. It also drives the shared 7-segment digit with either tank level or active zone. It sits between the raw board switches/sensors and the 7-segment and actuator pins.

---
 rtl/irrigacao_pkg.sv | 42 ++++
 rtl/filtro_nivel.sv | 32 +++
 rtl/irrigacao_multizona.sv | 126 ++++++++++++
 tb/tb_irrigacao_multizona.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/irrigacao_pkg.sv
// Shared types, 7-segment glyphs and helpers for the multi-zone irrigation controller.
package irrigacao_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        REGA,
        PAUSA
    } estado_t;

    // Segment order is seg[6:0] = {a, b, c, d, e, f, g}, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_TRACO = 7'h01;

    function automatic logic [2:0] codigo_nivel(input logic a, input logic m, input logic b);
        if (a)      return 3'd3;
        else if (m) return 3'd2;
        else if (b) return 3'd1;
        else        return 3'd0;
    endfunction

    function automatic logic [6:0] seg_digito(input logic [2:0] d);
        unique case (d)
            3'd0:    return SEG_0;
            3'd1:    return SEG_1;
            3'd2:    return SEG_2;
            3'd3:    return SEG_3;
            3'd4:    return SEG_4;
            3'd5:    return SEG_5;
            3'd6:    return SEG_6;
            default: return SEG_7;
        endcase
    endfunction

endpackage

// File: rtl/filtro_nivel.sv
// One-bit debouncer: the filtered value follows the raw input only after it has
// differed for T_DEB consecutive clock edges.
module filtro_nivel #(
    parameter int T_DEB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bruto,
    output logic filtrado
);

    localparam int CW = $clog2(T_DEB);
    localparam logic [CW-1:0] LIM = CW'(T_DEB - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtrado <= 1'b0;
            cnt      <= '0;
        end else if (bruto == filtrado) begin
            cnt <= '0;
        end else if (cnt == LIM) begin
            filtrado <= bruto;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: level filtering, alarm, refill valve,
// round-robin zone scheduler and shared 7-segment display.
module irrigacao_multizona
    import irrigacao_pkg::*;
#(
    parameter int N_ZONAS = 4,
    parameter int T_DEB   = 4,
    parameter int T_REGA  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nivel_a,
    input  logic               nivel_m,
    input  logic               nivel_b,
    input  logic [N_ZONAS-1:0] umid_solo,
    input  logic               umid_ar,
    input  logic               temp,
    input  logic               sel_disp,
    output logic               alarme,
    output logic               valvula,
    output logic [N_ZONAS-1:0] gotejamento,
    output logic [N_ZONAS-1:0] aspersao,
    output logic [6:0]         seg,
    output logic [2:0]         zona_ativa
);

    localparam int CW = $clog2(T_REGA);
    localparam logic [CW-1:0]      CNT_LIM = CW'(T_REGA - 1);
    localparam logic [2:0]         ZONA_MAX = 3'(N_ZONAS - 1);
    localparam logic [N_ZONAS-1:0] UM = 1;

    logic f_a, f_m, f_b;
    logic alarme_c;

    estado_t       estado, estado_prox;
    logic [2:0]    zona, zona_prox, ptr, ptr_prox, candidata;
    logic [CW-1:0] cnt, cnt_prox;
    logic          modo_gotejo, modo_prox;
    logic          achou, pedido_zona;
    logic [N_ZONAS-1:0] sel_oh;

    filtro_nivel #(.T_DEB(T_DEB)) u_filtro_a (.clk(clk), .rst(rst), .bruto(nivel_a), .filtrado(f_a));
    filtro_nivel #(.T_DEB(T_DEB)) u_filtro_m (.clk(clk), .rst(rst), .bruto(nivel_m), .filtrado(f_m));
    filtro_nivel #(.T_DEB(T_DEB)) u_filtro_b (.clk(clk), .rst(rst), .bruto(nivel_b), .filtrado(f_b));

    assign alarme_c    = (f_a & ~f_m) | (f_a & ~f_b) | (f_m & ~f_b) | ~f_b;
    assign sel_oh      = UM << zona;
    assign pedido_zona = |(umid_solo & sel_oh);

    // First requesting zone at or after ptr, wrapping around.
    always_comb begin
        achou     = 1'b0;
        candidata = '0;
        for (int i = 0; i < N_ZONAS; i++) begin
            if (!achou && |(umid_solo & (UM << ((int'(ptr) + i) % N_ZONAS)))) begin
                achou     = 1'b1;
                candidata = 3'((int'(ptr) + i) % N_ZONAS);
            end
        end
    end

    // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
    always_comb begin
        estado_prox = estado;
        zona_prox   = zona;
        modo_prox   = modo_gotejo;
        cnt_prox    = cnt;
        ptr_prox    = ptr;
        unique case (estado)
            OCIOSO: begin
                if (!alarme && achou) begin
                    zona_prox   = candidata;
                    modo_prox   = temp | ~umid_ar | ~f_m;
                    cnt_prox    = '0;
                    estado_prox = REGA;
                end
            end
            REGA: begin
                cnt_prox = cnt + 1'b1;
                if (alarme)
                    estado_prox = OCIOSO;
                else if (!pedido_zona || cnt == CNT_LIM)
                    estado_prox = PAUSA;
            end
            PAUSA: begin
                ptr_prox    = (zona == ZONA_MAX) ? 3'd0 : zona + 3'd1;
                estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            zona        <= '0;
            ptr         <= '0;
            cnt         <= '0;
            modo_gotejo <= 1'b0;
            alarme      <= 1'b0;
            valvula     <= 1'b0;
            seg         <= '0;
        end else begin
            estado      <= estado_prox;
            zona        <= zona_prox;
            ptr         <= ptr_prox;
            cnt         <= cnt_prox;
            modo_gotejo <= modo_prox;
            alarme      <= alarme_c;
            // Closing wins over opening; otherwise the valve holds (hysteresis between M and A).
            if (f_a || alarme_c)
                valvula <= 1'b0;
            else if (!f_m)
                valvula <= 1'b1;
            if (sel_disp)
                seg <= (estado == REGA) ? seg_digito(zona) : SEG_TRACO;
            else
                seg <= alarme_c ? SEG_E : seg_digito(codigo_nivel(f_a, f_m, f_b));
        end
    end

    assign gotejamento = (estado == REGA &&  modo_gotejo) ? sel_oh : '0;
    assign aspersao    = (estado == REGA && !modo_gotejo) ? sel_oh : '0;
    assign zona_ativa  = zona;

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench for irrigacao_multizona (N_ZONAS=4, T_DEB=4, T_REGA=8).
module tb_irrigacao_multizona;

    logic       clk = 1'b0;
    logic       rst;
    logic       nivel_a, nivel_m, nivel_b;
    logic [3:0] umid_solo;
    logic       umid_ar, temp, sel_disp;
    logic       alarme, valvula;
    logic [3:0] gotejamento, aspersao;
    logic [6:0] seg;
    logic [2:0] zona_ativa;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    irrigacao_multizona dut (
        .clk(clk), .rst(rst),
        .nivel_a(nivel_a), .nivel_m(nivel_m), .nivel_b(nivel_b),
        .umid_solo(umid_solo), .umid_ar(umid_ar), .temp(temp), .sel_disp(sel_disp),
        .alarme(alarme), .valvula(valvula),
        .gotejamento(gotejamento), .aspersao(aspersao),
        .seg(seg), .zona_ativa(zona_ativa)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; nivel_a = 1'b0; nivel_m = 1'b0; nivel_b = 1'b0;
        umid_solo = 4'b0000; umid_ar = 1'b1; temp = 1'b0; sel_disp = 1'b0;
        step(2);
        check("rst_alarme", 32'(alarme), 32'd0);
        check("rst_valvula", 32'(valvula), 32'd0);
        check("rst_gotej", 32'(gotejamento), 32'd0);
        check("rst_asper", 32'(aspersao), 32'd0);
        check("rst_zona", 32'(zona_ativa), 32'd0);
        check("rst_seg", 32'(seg), 32'h00);

        // Full tank
        rst = 1'b0; nivel_a = 1'b1; nivel_m = 1'b1; nivel_b = 1'b1;
        step(5);
        check("cheio_alarme", 32'(alarme), 32'd0);
        check("cheio_valvula", 32'(valvula), 32'd0);
        check("cheio_seg3", 32'(seg), 32'h79);

        // Low level only: valid, valve opens
        nivel_a = 1'b0; nivel_m = 1'b0;
        step(6);
        check("baixo_alarme", 32'(alarme), 32'd0);
        check("baixo_valvula", 32'(valvula), 32'd1);
        check("baixo_seg1", 32'(seg), 32'h30);

        // 3-cycle glitch on B is rejected
        nivel_b = 1'b0; step(3); nivel_b = 1'b1;
        step(6);
        check("pulso_alarme", 32'(alarme), 32'd0);
        check("pulso_seg1", 32'(seg), 32'h30);

        // B held low: filtered on the 4th edge, alarm one edge later
        nivel_b = 1'b0;
        step(4);
        check("vazio_ainda", 32'(alarme), 32'd0);
        step(1);
        check("vazio_alarme", 32'(alarme), 32'd1);
        check("vazio_segE", 32'(seg), 32'h4F);
        check("vazio_valvula", 32'(valvula), 32'd0);

        // Valve hysteresis
        nivel_b = 1'b1; nivel_m = 1'b1;
        step(5);
        check("medio_alarme", 32'(alarme), 32'd0);
        check("medio_valv_hold0", 32'(valvula), 32'd0);
        check("medio_seg2", 32'(seg), 32'h6D);
        nivel_m = 1'b0;
        step(5);
        check("m_cai_valvula", 32'(valvula), 32'd1);
        check("m_cai_seg1", 32'(seg), 32'h30);
        nivel_m = 1'b1;
        step(5);
        check("m_sobe_hold1", 32'(valvula), 32'd1);
        nivel_a = 1'b1;
        step(4);
        check("a_filtra_hold1", 32'(valvula), 32'd1);
        step(1);
        check("a_fecha", 32'(valvula), 32'd0);
        check("a_seg3", 32'(seg), 32'h79);

        // Zones 1 and 3 dry, sprinkler mode, full turn of zone 1
        umid_solo = 4'b1010; temp = 1'b0; umid_ar = 1'b1; sel_disp = 1'b1;
        step(1);
        check("z1_asper", 32'(aspersao), 32'h2);
        check("z1_gotej", 32'(gotejamento), 32'h0);
        check("z1_zona", 32'(zona_ativa), 32'd1);
        step(1);
        check("z1_asper_c2", 32'(aspersao), 32'h2);
        check("z1_seg", 32'(seg), 32'h30);
        for (int i = 3; i <= 8; i++) begin
            step(1);
            check("z1_asper_turno", 32'(aspersao), 32'h2);
        end
        step(1);
        check("z1_pausa", 32'(aspersao), 32'h0);
        step(1);
        check("z1_ocioso", 32'(aspersao), 32'h0);
        step(1);
        check("z3_asper", 32'(aspersao), 32'h8);
        check("z3_zona", 32'(zona_ativa), 32'd3);

        // Zone 3 satisfied early
        umid_solo = 4'b0000;
        step(1);
        check("z3_fim", 32'(aspersao), 32'h0);
        step(2);

        // Zone 2 drip, cut short on its third cycle
        umid_solo = 4'b0100; temp = 1'b1;
        step(1);
        check("z2_gotej", 32'(gotejamento), 32'h4);
        check("z2_asper", 32'(aspersao), 32'h0);
        check("z2_zona", 32'(zona_ativa), 32'd2);
        step(2);
        check("z2_gotej_c3", 32'(gotejamento), 32'h4);
        umid_solo = 4'b1010;
        step(1);
        check("z2_corte", 32'(gotejamento), 32'h0);
        step(1);
        check("z2_pausa", 32'(gotejamento), 32'h0);
        check("z2_seg_traco", 32'(seg), 32'h01);
        step(1);
        check("ptr3_gotej", 32'(gotejamento), 32'h8);
        check("ptr3_zona", 32'(zona_ativa), 32'd3);

        // Move on to zone 0
        umid_solo = 4'b0001;
        step(3);
        check("z0_gotej", 32'(gotejamento), 32'h1);
        check("z0_zona", 32'(zona_ativa), 32'd0);

        // Alarm while zone 0 irrigates
        nivel_b = 1'b0;
        step(5);
        check("al_sobe", 32'(alarme), 32'd1);
        check("al_transicao", 32'(gotejamento), 32'h1);
        step(1);
        check("al_gotej_off", 32'(gotejamento), 32'h0);
        check("al_asper_off", 32'(aspersao), 32'h0);
        nivel_b = 1'b1;
        step(4);
        check("al_mantido", 32'(alarme), 32'd1);
        check("al_mantido_off", 32'(gotejamento), 32'h0);
        step(1);
        check("al_limpo", 32'(alarme), 32'd0);
        check("al_limpo_off", 32'(gotejamento), 32'h0);
        step(1);
        check("z0_retoma", 32'(gotejamento), 32'h1);
        check("z0_retoma_zona", 32'(zona_ativa), 32'd0);

        // Reset mid-turn
        rst = 1'b1;
        step(1);
        check("rst2_gotej", 32'(gotejamento), 32'h0);
        check("rst2_asper", 32'(aspersao), 32'h0);
        check("rst2_seg", 32'(seg), 32'h00);
        check("rst2_zona", 32'(zona_ativa), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
